// File: rtl/controller.sv
// Four-stage instruction controller: accepts one instruction at a time, steps
// it through FETCH, EXEC and WB, and decodes the latched instruction register
// into datapath selects and fields. Illegal encodings drop out after FETCH.
module controller #(
  parameter int DataSize = 32,
  parameter int AddrSize = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DataSize-1:0] instruction,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [AddrSize-1:0] read_address1,
  output logic [AddrSize-1:0] read_address2,
  output logic [AddrSize-1:0] write_address,
  output logic                enable_fetch,
  output logic                enable_execute,
  output logic                enable_writeback,
  output logic [4:0]          imm_5bit,
  output logic [14:0]         imm_15bit,
  output logic [19:0]         imm_20bit,
  output logic [1:0]          mux4to1_select,
  output logic                mux2to1_select,
  output logic                imm_reg_select,
  output logic [5:0]          opcode,
  output logic [4:0]          sub_opcode,
  output logic                illegal_instr,
  output logic [15:0]         retired_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] WB    = 2'd3;

  localparam logic [5:0] OpAlu1 = 6'b100000;
  localparam logic [5:0] OpMovi = 6'b100010;
  localparam logic [5:0] OpAddi = 6'b101000;
  localparam logic [5:0] OpOri  = 6'b101100;
  localparam logic [5:0] OpXori = 6'b101011;

  logic [1:0]          state_q, state_d;
  logic [DataSize-1:0] ir_q;
  logic [15:0]         count_q;

  logic                legal;
  logic                dec_imm_sel;
  logic [1:0]          dec_mux4;
  logic                dec_mux2;

  logic                accept;

  assign accept = (state_q == IDLE) && instr_valid;

  // Decode the instruction register into legality and operand selects.
  always_comb begin
    legal       = 1'b0;
    dec_imm_sel = 1'b0;
    dec_mux4    = 2'b00;
    dec_mux2    = 1'b0;
    if (!ir_q[31]) begin
      case (ir_q[30:25])
        OpAlu1: begin
          case (ir_q[4:0])
            5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100: begin
              legal = 1'b1;
            end
            5'b01000, 5'b01001, 5'b01011: begin
              legal       = 1'b1;
              dec_imm_sel = 1'b1;
            end
            default: legal = 1'b0;
          endcase
        end
        OpMovi: begin
          legal       = 1'b1;
          dec_imm_sel = 1'b1;
          dec_mux4    = 2'b11;
          dec_mux2    = 1'b1;
        end
        OpAddi: begin
          legal       = 1'b1;
          dec_imm_sel = 1'b1;
          dec_mux4    = 2'b01;
        end
        OpOri, OpXori: begin
          legal       = 1'b1;
          dec_imm_sel = 1'b1;
          dec_mux4    = 2'b10;
        end
        default: legal = 1'b0;
      endcase
    end
  end

  // Next-state logic; an illegal instruction returns to IDLE after FETCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FETCH;
      FETCH:   state_d = legal ? EXEC : IDLE;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, instruction register and retirement counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ir_q <= instruction;
      end
      if (state_q == WB) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  // Stage enables and handshake.
  always_comb begin
    instr_ready      = (state_q == IDLE);
    enable_fetch     = (state_q == FETCH);
    enable_execute   = (state_q == EXEC);
    enable_writeback = (state_q == WB);
    illegal_instr    = (state_q == FETCH) && !legal;
  end

  // Raw fields come straight from IR so they hold until the next accept.
  always_comb begin
    write_address  = ir_q[24:20];
    read_address1  = ir_q[19:15];
    read_address2  = ir_q[14:10];
    imm_5bit       = ir_q[14:10];
    imm_15bit      = ir_q[14:0];
    imm_20bit      = ir_q[19:0];
    opcode         = ir_q[30:25];
    sub_opcode     = ir_q[4:0];
    mux4to1_select = dec_mux4;
    mux2to1_select = dec_mux2;
    imm_reg_select = dec_imm_sel;
    retired_count  = count_q;
  end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameter: DataSize, 32, instruction word width.
REQ-002 Parameter: AddrSize, 5, register address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 instruction  input  DataSize  32-bit instruction word.
REQ-006 instr_valid  input  1  upstream asserts when instruction is valid.
REQ-007 instr_ready  output  1  high when the controller can accept an instruction.
REQ-008 read_address1, read_address2, write_address  output  AddrSize each  Ra, Rb, Rt.
REQ-009 enable_fetch, enable_execute, enable_writeback  output  1 each  stage enables to the datapath.
REQ-010 imm_5bit  output  5;  imm_15bit  output  15;  imm_20bit  output  20  raw immediate fields.
REQ-011 mux4to1_select  output  2  immediate extension: 00 imm5 ZE, 01 imm15 SE, 10 imm15 ZE, 11 imm20 SE.
REQ-012 mux2to1_select  output  1  0 = ALU result, 1 = src2 (immediate pass-through).
REQ-013 imm_reg_select  output  1  0 = register operand, 1 = immediate operand.
REQ-014 opcode  output  6;  sub_opcode  output  5  ALU control.
REQ-015 illegal_instr  output  1  one-cycle pulse on an undecodable instruction.
REQ-016 retired_count  output  16  count of completed writebacks.

Function
REQ-017 Field map: bit31 = 0 required; opcode = [30:25]; Rt = [24:20]; Ra = [19:15]; Rb/imm5 = [14:10]; imm15 = [14:0]; imm20 = [19:0]; sub_opcode = [4:0].
REQ-018 FSM states: IDLE, FETCH, EXEC, WB; IDLE -> FETCH on instr_valid && instr_ready; FETCH -> EXEC; EXEC -> WB; WB -> IDLE.
REQ-019 instr_ready = 1 only in IDLE; instruction is latched into an internal IR on the accepting edge.
REQ-020 enable_fetch = 1 only in FETCH, enable_execute only in EXEC, enable_writeback only in WB; at most one enable is high per cycle.
REQ-021 Latency: accepted at edge N; fetch cycle N+1, exec N+2, wb N+3, ready again N+4; throughput 1 instruction per 4 cycles.
REQ-022 All decoded outputs are driven from IR and held stable from FETCH through WB; instruction input changes after acceptance have no effect.
REQ-023 Decode ALU_1 (opcode 100000): sub 00000 ADD, 00001 SUB, 00010 AND, 00011 XOR, 00100 OR -> imm_reg_select 0, mux2to1 0; sub 01000 SLLI, 01001 SRLI, 01011 ROTRI -> imm_reg_select 1, mux4to1 00, mux2to1 0.
REQ-024 MOVI 100010 -> imm 1, mux4to1 11, mux2to1 1; ADDI 101000 -> imm 1, mux4to1 01, mux2to1 0; ORI 101100, XORI 101011 -> imm 1, mux4to1 10, mux2to1 0.
REQ-025 NOP is SRLI R0,R0,0 and is executed as a normal instruction.
REQ-026 Illegal (bit31 = 1, unlisted opcode, or unlisted ALU_1 sub_opcode): FETCH -> IDLE, illegal_instr pulses in the FETCH cycle, no EXEC/WB, retired_count unchanged.
REQ-027 retired_count increments by 1 on each WB cycle; wraps 0xFFFF -> 0x0000.
REQ-028 instr_valid while not in IDLE is ignored (not accepted, not queued).

Reset
REQ-029 On rst high at an edge: state IDLE, IR = 0, retired_count = 0, all enables 0, illegal_instr 0, all decoded outputs 0.
REQ-030 Reset mid-instruction aborts it: no further enable pulses, no count increment; instr_ready = 1 in the first cycle after rst deasserts.

Verification
REQ-031 MOVI R0,200 (0x440000C8) -> fetch/exec/wb on cycles N+1..N+3; write_address 0, imm_20bit 200, mux4to1 11, mux2to1 1, imm_reg 1; retired_count 1.
REQ-032 ADDI R1,R0,100 (0x50100064) then ADD R2,R0,R1 (0x40200400) back-to-back valid -> second accepted at N+4; ADD: imm_reg 0, opcode 100000, sub 00000, Rb 1.
REQ-033 SLLI R2,R0,3 (0x40200C08) -> imm_5bit 3, mux4to1 00, imm_reg 1, sub_opcode 01000.
REQ-034 ORI R2,R0,0x4064 (0x58204064) -> imm_15bit 0x4064, mux4to1 10; instruction input changed during EXEC -> outputs unchanged.
REQ-035 Illegal 0x7E000000 -> illegal_instr high one cycle at N+1, no exec/wb, ready at N+2, retired_count unchanged.
REQ-036 rst asserted during EXEC -> next cycle all enables 0, outputs 0, count unchanged from pre-instruction value, instr_ready 1 after release.
